// File: rtl/register_file_sb_if.sv
// Decode/Writeback/hazard-unit bundle for the integer register file.
// The master drives addresses, write data and issue info; the slave returns read data and busy flags.
interface register_file_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   A1;
    logic [AW-1:0]   A2;
    logic [XLEN-1:0] RD1;
    logic [XLEN-1:0] RD2;
    logic            WE3;
    logic [AW-1:0]   A3;
    logic [XLEN-1:0] WD3;
    logic            IssueEn;
    logic [AW-1:0]   IssueRd;
    logic            Busy1;
    logic            Busy2;
    logic            SbOvf;

    modport master (
        output A1, A2, WE3, A3, WD3, IssueEn, IssueRd,
        input  RD1, RD2, Busy1, Busy2, SbOvf
    );

    modport slave (
        input  A1, A2, WE3, A3, WD3, IssueEn, IssueRd,
        output RD1, RD2, Busy1, Busy2, SbOvf
    );
endinterface

// File: rtl/register_file_sb.sv
// RISC-V integer register file with same-cycle write-to-read bypass and a
// per-register pending-write scoreboard for the hazard unit.
module register_file_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int SBW  = 2
) (
    input logic               clk,
    input logic               rst,
    register_file_sb_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam logic [SBW-1:0] CMAX = {SBW{1'b1}};

    // Entry 0 of both arrays is never written, so it stays at its reset value of 0.
    logic [XLEN-1:0] r_regs [NREG];
    logic [SBW-1:0]  r_cnt  [NREG];
    logic            r_sbOvf;

    logic [NREG-1:0] w_inc;
    logic [NREG-1:0] w_dec;
    logic [NREG-1:0] w_sat;
    logic            w_ovfHit;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        w_sat = '0;
        for (int r = 0; r < NREG; r++) begin
            w_inc[r] = bus.IssueEn && (bus.IssueRd == AW'(r)) && (r != 0);
            w_dec[r] = bus.WE3 && (bus.A3 == AW'(r)) && (r != 0);
            w_sat[r] = (r_cnt[r] == CMAX);
        end
        w_ovfHit = |(w_inc & ~w_dec & w_sat);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
                r_cnt[r]  <= '0;
            end
            r_sbOvf <= 1'b0;
        end else begin
            if (bus.WE3 && (bus.A3 != '0)) begin
                r_regs[bus.A3] <= bus.WD3;
            end
            for (int r = 0; r < NREG; r++) begin
                if (w_inc[r] && !w_dec[r]) begin
                    if (!w_sat[r]) begin
                        r_cnt[r] <= r_cnt[r] + 1'b1;
                    end
                end else if (w_dec[r] && !w_inc[r]) begin
                    if (r_cnt[r] != '0) begin
                        r_cnt[r] <= r_cnt[r] - 1'b1;
                    end
                end
            end
            if (w_ovfHit) begin
                r_sbOvf <= 1'b1;
            end
        end
    end

    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic [SBW-1:0]  w_cnt1;
    logic [SBW-1:0]  w_cnt2;
    logic            w_wbHit1;
    logic            w_wbHit2;
    logic            w_busy1;
    logic            w_busy2;

    // A writer completing this cycle no longer counts as outstanding for Decode.
    always_comb begin
        w_rd1    = '0;
        w_rd2    = '0;
        w_cnt1   = r_cnt[bus.A1];
        w_cnt2   = r_cnt[bus.A2];
        w_wbHit1 = bus.WE3 && (bus.A3 == bus.A1);
        w_wbHit2 = bus.WE3 && (bus.A3 == bus.A2);
        w_busy1  = 1'b0;
        w_busy2  = 1'b0;
        if (rst && (bus.A1 != '0)) begin
            w_rd1   = w_wbHit1 ? bus.WD3 : r_regs[bus.A1];
            w_busy1 = (w_cnt1 - SBW'(w_wbHit1 && (w_cnt1 != '0))) != '0;
        end
        if (rst && (bus.A2 != '0)) begin
            w_rd2   = w_wbHit2 ? bus.WD3 : r_regs[bus.A2];
            w_busy2 = (w_cnt2 - SBW'(w_wbHit2 && (w_cnt2 != '0))) != '0;
        end
    end

    assign bus.RD1   = w_rd1;
    assign bus.RD2   = w_rd2;
    assign bus.Busy1 = w_busy1;
    assign bus.Busy2 = w_busy2;
    assign bus.SbOvf = r_sbOvf;
endmodule
